// File: rtl/rrf_alloc.sv
// rrf_alloc: rename-register / ROB tag allocator on the dispatch side.
//
// Owns the dispatch pointer and the free-entry count. Up to two tags are
// granted per cycle, combinationally on the request. Entries are reclaimed as
// the ROB reports commits. A misprediction rolls the dispatch pointer back to
// just past the mispredicted branch and rebuilds the free count and busy map
// from the ROB commit pointer.
//
// Ports
//   clk             clock, all state on the rising edge
//   reset           asynchronous, active-high
//   req1, req2      dispatch slot requests (req2 only counts together with req1)
//   stall_dp        dispatch must hold this cycle
//   dp1, dp2        per-slot grants (all-or-nothing)
//   dp1_addr        tag for slot 1 (= dispatchptr)
//   dp2_addr        tag for slot 2 (= dispatchptr + 1, wrapping)
//   dispatchptr     next tag to allocate (registered)
//   rrf_freenum     free entries, 0..RRF_NUM (registered)
//   comnum          entries committed this cycle (0..2)
//   comptr          ROB commit pointer (oldest live tag)
//   prmiss          misprediction recovery this cycle
//   prmiss_tag      tag of the mispredicted branch
//   busy            bit i set while tag i is allocated and uncommitted
//   err_overcommit  sticky; a commit exceeded the live count
module rrf_alloc #(
   parameter int unsigned RRF_NUM = 64,
   parameter int unsigned RRF_SEL = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req1,
   input  logic               req2,
   output logic               stall_dp,
   output logic               dp1,
   output logic               dp2,
   output logic [RRF_SEL-1:0] dp1_addr,
   output logic [RRF_SEL-1:0] dp2_addr,
   output logic [RRF_SEL-1:0] dispatchptr,
   output logic [RRF_SEL:0]   rrf_freenum,
   input  logic [1:0]         comnum,
   input  logic [RRF_SEL-1:0] comptr,
   input  logic               prmiss,
   input  logic [RRF_SEL-1:0] prmiss_tag,
   output logic [RRF_NUM-1:0] busy,
   output logic               err_overcommit
);

   localparam logic [RRF_SEL:0]   FullCount = (RRF_SEL+1)'(RRF_NUM);
   localparam logic [RRF_SEL+1:0] FullWide  = (RRF_SEL+2)'(RRF_NUM);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [RRF_SEL-1:0] dispatchptr_q, dispatchptr_d;
   logic [RRF_SEL:0]   freenum_q, freenum_d;
   logic [RRF_NUM-1:0] busy_q, busy_d;
   logic               err_q, err_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dispatchptr_q <= '0;
         freenum_q     <= FullCount;
         busy_q        <= '0;
         err_q         <= 1'b0;
      end else begin
         dispatchptr_q <= dispatchptr_d;
         freenum_q     <= freenum_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
      end
   end

   assign dispatchptr    = dispatchptr_q;
   assign rrf_freenum    = freenum_q;
   assign busy           = busy_q;
   assign err_overcommit = err_q;

   // ------------------------------------------------------------------------
   // Grant logic
   // ------------------------------------------------------------------------
   logic [1:0] need;
   logic [1:0] grants;

   // A lone req2 contributes nothing to the demand and is never granted.
   assign need     = {1'b0, req1} + {1'b0, req1 & req2};
   // Frees from this cycle's commits are deliberately not visible here.
   assign stall_dp = prmiss | (freenum_q < (RRF_SEL+1)'(need));
   assign dp1      = req1 & ~stall_dp;
   assign dp2      = req1 & req2 & ~stall_dp;
   assign grants   = {1'b0, dp1} + {1'b0, dp2};

   assign dp1_addr = dispatchptr_q;
   assign dp2_addr = dispatchptr_q + RRF_SEL'(1);

   // ------------------------------------------------------------------------
   // Free count
   // ------------------------------------------------------------------------
   // One extra bit so that freenum + comnum beyond RRF_NUM is observable.
   logic [RRF_SEL+1:0] avail;
   logic [RRF_SEL+1:0] avail_sat;
   logic               overcommit;
   logic [RRF_SEL-1:0] live_m1;
   logic [RRF_SEL:0]   live;

   assign avail      = {1'b0, freenum_q} + (RRF_SEL+2)'(comnum);
   assign overcommit = ~prmiss & (avail > FullWide);
   assign avail_sat  = overcommit ? FullWide : avail;

   // Live window after recovery is comptr..prmiss_tag inclusive, size 1..RRF_NUM.
   assign live_m1 = prmiss_tag - comptr;
   assign live    = (RRF_SEL+1)'(live_m1) + (RRF_SEL+1)'(1);

   // ------------------------------------------------------------------------
   // Per-tag masks
   // ------------------------------------------------------------------------
   logic [RRF_NUM-1:0] commit_mask;
   logic [RRF_NUM-1:0] live_mask;
   logic [RRF_NUM-1:0] grant_mask;

   for (genvar g = 0; g < RRF_NUM; g++) begin : g_tag
      logic [RRF_SEL-1:0] off;

      // Distance of this tag from the commit pointer, modulo RRF_NUM.
      assign off            = RRF_SEL'(g) - comptr;
      assign commit_mask[g] = {1'b0, off} < (RRF_SEL+1)'(comnum);
      assign live_mask[g]   = off <= live_m1;
      assign grant_mask[g]  = (dp1 & (dp1_addr == RRF_SEL'(g))) |
                              (dp2 & (dp2_addr == RRF_SEL'(g)));
   end

   // ------------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------------
   always_comb begin
      dispatchptr_d = dispatchptr_q;
      freenum_d     = freenum_q;
      busy_d        = busy_q;
      err_d         = err_q | overcommit;

      if (prmiss) begin
         // The ROB holds comptr during recovery, so comnum is ignored.
         dispatchptr_d = prmiss_tag + RRF_SEL'(1);
         freenum_d     = FullCount - live;
         busy_d        = live_mask;
      end else begin
         dispatchptr_d = dispatchptr_q + RRF_SEL'(grants);
         // The stall guarantees avail_sat >= grants, so this cannot underflow.
         freenum_d     = avail_sat[RRF_SEL:0] - (RRF_SEL+1)'(grants);
         busy_d        = (busy_q & ~commit_mask) | grant_mask;
      end
   end

   // ------------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------------
   a_pair_not_split : assert property (@(posedge clk) disable iff (reset)
      dp2 |-> dp1);

   a_count_in_range : assert property (@(posedge clk) disable iff (reset)
      freenum_q <= FullCount);

   a_grant_covered : assert property (@(posedge clk) disable iff (reset)
      (freenum_q >= (RRF_SEL+1)'(grants)));

   // Busy map and free count describe the same window unless commits overran it.
   a_busy_matches_count : assert property (@(posedge clk) disable iff (reset || err_q)
      ($countones(busy_q) == int'(FullCount - freenum_q)));

endmodule

// File: doc/rrf_alloc.md
# rrf_alloc

Rename-register (RRF) allocator feeding the reorder buffer from the dispatch side. It owns the dispatch pointer and the free-entry count, and grants up to two RRF/ROB tags per cycle to the dispatch stage. It reclaims entries as the ROB reports commits. On a branch misprediction it rolls the dispatch pointer back to just after the mispredicted branch and recomputes the free count from the ROB commit pointer.

## Interface
- RRF_NUM, 64, number of RRF/ROB entries (power of two)
- RRF_SEL, 6, log2(RRF_NUM)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req1  in  1  dispatch slot 1 wants a tag
- req2  in  1  dispatch slot 2 wants a tag (meaningful only with req1)
- stall_dp  out  1  dispatch must hold this cycle
- dp1  out  1  slot 1 granted
- dp2  out  1  slot 2 granted
- dp1_addr  out  RRF_SEL  tag for slot 1
- dp2_addr  out  RRF_SEL  tag for slot 2
- dispatchptr  out  RRF_SEL  next tag to allocate (registered)
- rrf_freenum  out  RRF_SEL+1  free entries, 0..RRF_NUM (registered)
- comnum  in  2  entries committed this cycle (0..2)
- comptr  in  RRF_SEL  ROB commit pointer (oldest live tag)
- prmiss  in  1  misprediction recovery this cycle
- prmiss_tag  in  RRF_SEL  tag of the mispredicted branch
- busy  out  RRF_NUM  bit i set while tag i is allocated and uncommitted (registered)
- err_overcommit  out  1  sticky; commit exceeded the live count

## Operation
- need = req1 + (req1 & req2). A lone req2 is ignored and never granted.
- stall_dp = prmiss | (rrf_freenum < need). This is combinational from registered rrf_freenum, so frees from this cycle's comnum are not visible until the next cycle.
- dp1 = req1 & ~stall_dp; dp2 = req1 & req2 & ~stall_dp. Grants are all-or-nothing: a pair is never split.
- dp1_addr = dispatchptr; dp2_addr = dispatchptr + 1, mod RRF_NUM (wraps 63 -> 0).
- Normal cycle (prmiss = 0):
  - dispatchptr += dp1 + dp2, mod RRF_NUM.
  - rrf_freenum += comnum - (dp1 + dp2), computed at RRF_SEL+1 bits.
  - busy: set the bits of granted tags; clear comnum bits starting at comptr (wrapping).
- Recovery cycle (prmiss = 1):
  - comnum is ignored, because the ROB holds comptr during recovery. No grants.
  - live = ((prmiss_tag - comptr) mod RRF_NUM) + 1, range 1..RRF_NUM.
  - dispatchptr <= prmiss_tag + 1 (mod RRF_NUM).
  - rrf_freenum <= RRF_NUM - live.
  - busy <= exactly the bits from comptr through prmiss_tag inclusive, wrapping.
- Full: rrf_freenum = 0 and dispatchptr = comptr. Empty: rrf_freenum = RRF_NUM and dispatchptr = comptr. The two are distinguished only by rrf_freenum.
- Overcommit: if rrf_freenum + comnum > RRF_NUM on a non-prmiss cycle, set err_overcommit. It stays set until reset, and rrf_freenum saturates at RRF_NUM.
- Simultaneous commit and dispatch in one cycle both apply; the net change to rrf_freenum is comnum - grants.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - dispatchptr = 0, rrf_freenum = RRF_NUM, busy = 0, err_overcommit = 0.
  - Combinational outputs with req = 0: stall_dp = 0, dp1 = dp2 = 0, dp1_addr = 0, dp2_addr = 1.
- Grant latency is 0 cycles, combinational on req. Pointer, count and busy updates are visible 1 cycle later.
- Commit frees become grantable 1 cycle after comnum is presented.
- Recovery takes 1 cycle. Dispatch may resume in the cycle after prmiss deasserts, using the recomputed count.
- Reset mid-operation discards all state immediately, independent of clk.
- Legality: prmiss_tag must lie within the live window. The bench must not drive it elsewhere, and the result is undefined if it does.

## Test plan
- Reset, then req1 = req2 = 1 for 32 cycles with comnum = 0:
  - Tags 0..63 are granted in order.
  - Cycle 33 has stall_dp = 1 and rrf_freenum = 0; busy is all ones.
- From full, comnum = 2 with req1 = req2 = 1 in the same cycle:
  - That cycle stalls.
  - The next cycle grants tags 0 and 1 (wrap), and rrf_freenum returns to 0.
- rrf_freenum = 1 with req1 = req2 = 1:
  - stall_dp = 1 and neither slot is granted.
  - With req1 alone: dp1 = 1 and rrf_freenum becomes 0.
- comptr = 60, dispatchptr = 10, prmiss = 1, prmiss_tag = 2, comnum = 2:
  - Next cycle dispatchptr = 3 and rrf_freenum = 57.
  - busy = bits 60..63 and 0..2; comnum is ignored.
- rrf_freenum = 64, comnum = 1:
  - err_overcommit goes high and stays high.
  - rrf_freenum stays 64.
  - Assert reset asynchronously mid-cycle: all outputs return to their reset values before the next edge.
